// File: rtl/fun_cbrt_mul.sv
// rtl/fun_cbrt_mul.sv - multi-cycle result = a * floor(cbrt(b)) for 8-bit unsigned operands
module fun_cbrt_mul (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    input  logic        i_start,
    output logic [10:0] o_result,
    output logic        o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_CBRT, S_MUL} state_t;

    state_t      r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_x;
    logic [2:0]  r_y;
    logic [1:0]  r_cnt;
    logic        r_phase;
    logic [11:0] r_t;
    logic [10:0] r_acc;
    logic [10:0] r_result;
    logic        r_busy;

    logic [2:0]  w_y2;
    logic [11:0] w_y2e;
    logic [11:0] w_tb;
    logic [11:0] w_t;
    logic [2:0]  w_shift;
    logic [10:0] w_term;
    logic [10:0] w_acc_next;

    // Trial subtrahend for the next root digit: (3*y*(y+1)+1) scaled to the current cube position.
    always_comb begin
        w_y2  = {r_y[1:0], 1'b0};
        w_y2e = {9'd0, w_y2};
        case (r_cnt)
            2'd0:    w_shift = 3'd6;
            2'd1:    w_shift = 3'd3;
            default: w_shift = 3'd0;
        endcase
        w_tb = 12'd3 * w_y2e * (w_y2e + 12'd1) + 12'd1;
        w_t  = w_tb << w_shift;
    end

    always_comb begin
        w_term     = r_y[r_cnt] ? ({3'd0, r_a} << r_cnt) : 11'd0;
        w_acc_next = r_acc + w_term;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_a      <= 8'd0;
            r_x      <= 8'd0;
            r_y      <= 3'd0;
            r_cnt    <= 2'd0;
            r_phase  <= 1'b0;
            r_t      <= 12'd0;
            r_acc    <= 11'd0;
            r_result <= 11'd0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_x     <= i_b;
                        r_y     <= 3'd0;
                        r_cnt   <= 2'd0;
                        r_phase <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CBRT;
                    end
                end
                S_CBRT: begin
                    if (!r_phase) begin
                        r_y     <= w_y2;
                        r_t     <= w_t;
                        r_phase <= 1'b1;
                    end else begin
                        if ({4'd0, r_x} >= r_t) begin
                            r_x <= r_x - r_t[7:0];
                            r_y <= r_y + 3'd1;
                        end
                        r_phase <= 1'b0;
                        if (r_cnt == 2'd2) begin
                            r_cnt   <= 2'd0;
                            r_acc   <= 11'd0;
                            r_state <= S_MUL;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == 2'd2) begin
                        r_result <= w_acc_next;
                        r_busy   <= 1'b0;
                        r_cnt    <= 2'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_fun_cbrt_mul.sv
// tb/tb_fun_cbrt_mul.sv - randomized and directed checks of fun_cbrt_mul against a cycle-level reference
module tb_fun_cbrt_mul;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_a = 8'd0;
    logic [7:0]  i_b = 8'd0;
    logic        i_start = 1'b0;
    logic [10:0] o_result;
    logic        o_busy;

    int vectors = 0;
    int miscompares = 0;

    fun_cbrt_mul dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_start  (i_start),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic int cbrt_floor(input int b);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
        return r;
    endfunction

    // Reference: accept when idle, stay busy 9 edges, then publish a*floor(cbrt(b)).
    logic        m_busy = 1'b0;
    logic [10:0] m_res  = 11'd0;
    logic [10:0] m_pend = 11'd0;
    int          m_left = 0;

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_busy <= 1'b0;
            m_res  <= 11'd0;
            m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_res  <= m_pend;
            end
        end else if (i_start) begin
            m_busy <= 1'b1;
            m_left <= 9;
            m_pend <= 11'(int'(i_a) * cbrt_floor(int'(i_b)));
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        vectors++;
        if (o_busy !== m_busy || o_result !== m_res) begin
            miscompares++;
            $display("FAIL cycle t=%0t: busy=%0b result=%0d, expected busy=%0b result=%0d",
                     $time, o_busy, o_result, m_busy, m_res);
        end
    endtask

    task automatic run(input int a, input int b, input int exp, input bit disturb);
        int cyc;
        i_a = 8'(a);
        i_b = 8'(b);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0;
        while (o_busy === 1'b1 && cyc < 20) begin
            cyc++;
            if (disturb && cyc == 3) begin
                i_a = 8'd9;
                i_b = 8'd125;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            tick();
        end
        i_start = 1'b0;
        check($sformatf("busy_len a=%0d b=%0d", a, b), cyc, 9);
        if (exp >= 0) check($sformatf("result a=%0d b=%0d", a, b), int'(o_result), exp);
        tick();
    endtask

    initial begin
        int n;
        check("cbrt(255)", cbrt_floor(255), 6);
        check("cbrt(63)", cbrt_floor(63), 3);
        check("cbrt(64)", cbrt_floor(64), 4);
        check("cbrt(7)", cbrt_floor(7), 1);

        tick();
        tick();
        check("reset busy", int'(o_busy), 0);
        check("reset result", int'(o_result), 0);
        i_rst = 1'b0;
        tick();

        run(5, 27, 15, 1'b0);
        run(3, 64, 12, 1'b0);
        run(9, 125, 45, 1'b0);
        run(255, 255, 1530, 1'b0);
        run(200, 7, 200, 1'b0);
        run(100, 8, 200, 1'b0);
        run(17, 0, 0, 1'b0);
        run(0, 216, 0, 1'b0);
        run(5, 27, 15, 1'b1);

        // Abort mid-computation with reset.
        i_a = 8'd5; i_b = 8'd27; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick();
        i_rst = 1'b1;
        tick();
        check("abort busy", int'(o_busy), 0);
        check("abort result", int'(o_result), 0);
        i_rst = 1'b0;
        tick();
        run(3, 64, 12, 1'b0);

        // start held high: back-to-back runs with one idle cycle between them.
        i_a = 8'd9; i_b = 8'd125; i_start = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        i_start = 1'b0;
        n = 0;
        while (o_busy === 1'b1 && n < 12) begin n++; tick(); end
        check("b2b drain", (n < 12) ? 1 : 0, 1);
        check("b2b result", int'(o_result), 45);

        for (int b = 0; b < 256; b++) run(255, b, 255 * cbrt_floor(b), 1'b0);
        for (int k = 0; k < 200; k++) begin
            n = int'($urandom_range(0, 255));
            run(n, int'($urandom_range(0, 255)), -1, 1'b0);
        end

        // Free-running random start/operands/reset, checked cycle by cycle.
        for (int c = 0; c < 4000; c++) begin
            i_a = 8'($urandom);
            i_b = 8'($urandom);
            i_start = ($urandom_range(0, 2) == 0);
            i_rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        i_rst = 1'b0;
        i_start = 1'b0;
        for (int c = 0; c < 12; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
